// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Controls the instruction-fetch stage. After reset it boot-loads the
// instruction memory from a valid/ready stream, then releases the core. While
// running it drives the PC enable, the next-PC select and the IF/ID flush,
// resolving stall-versus-redirect priority. It also supports halt (with a
// bounded pipeline drain), resume and reload.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   load_valid   in   boot-load word valid
//   load_data    in   boot-load instruction word (32 bits)
//   load_ready   out  a boot-load word is accepted this cycle
//   imem_we      out  instruction memory write strobe
//   imem_waddr   out  instruction memory word address (ADDR_W bits)
//   imem_wdata   out  instruction memory write data (32 bits)
//   hazard_stall in   load-use stall from the hazard unit
//   branch_taken in   branch resolved taken
//   jump         in   jump resolved
//   halt_req     in   request to stop fetching
//   resume_req   in   restart fetching from HALT
//   reload_req   in   re-enter boot load from HALT
//   pc_write     out  PC register enable
//   pc_sel       out  0 = PC+4, 1 = redirect target
//   if_flush     out  flush the IF/ID register
//   core_run     out  core released (RUN or DRAIN)
//   state        out  00 LOAD, 01 RUN, 10 DRAIN, 11 HALT
//   fetch_count  out  PC updates since the last load (saturating)
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int DEPTH_WORDS  = 16,
  parameter int ADDR_W       = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic              hazard_stall,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              halt_req,
  input  logic              resume_req,
  input  logic              reload_req,
  output logic              pc_write,
  output logic              pc_sel,
  output logic              if_flush,
  output logic              core_run,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  wcnt_q, wcnt_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic               redirect;
  logic               clear_fcnt;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign redirect = branch_taken | jump;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    dcnt_d     = dcnt_q;
    clear_fcnt = 1'b0;
    load_ready = 1'b0;
    imem_we    = 1'b0;
    imem_waddr = wcnt_q;
    imem_wdata = load_data;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    if_flush   = 1'b0;
    core_run   = 1'b0;

    case (state_q)
      S_LOAD: begin
        load_ready = 1'b1;
        // Gate the strobe while reset is held so a stray valid cannot write.
        imem_we    = load_valid & reset;
        if (load_valid) begin
          if (wcnt_q == LAST_WORD) begin
            state_d = S_RUN;
            wcnt_d  = '0;
          end else begin
            wcnt_d  = wcnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        core_run = 1'b1;
        // A redirect must win over a stall or the wrong-path fetch survives.
        pc_write = redirect | ~hazard_stall;
        pc_sel   = redirect;
        if_flush = redirect;
        if (halt_req) begin
          state_d = S_DRAIN;
          dcnt_d  = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        core_run = 1'b1;
        // Sequential fetch is frozen; older in-flight branches still redirect.
        pc_write = redirect;
        pc_sel   = redirect;
        if_flush = redirect;
        if (dcnt_q == '0) begin
          state_d = S_HALT;
        end else begin
          dcnt_d  = dcnt_q - 1'b1;
        end
      end
      S_HALT: begin
        if (reload_req) begin
          state_d    = S_LOAD;
          clear_fcnt = 1'b1;
        end else if (resume_req) begin
          state_d    = S_RUN;
        end
      end
      default: state_d = S_LOAD;
    endcase

    if (clear_fcnt) begin
      fcnt_d = '0;
    end else if (pc_write) begin
      fcnt_d = sat_inc(fcnt_q);
    end else begin
      fcnt_d = fcnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      wcnt_q  <= '0;
      dcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      dcnt_q  <= dcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign state       = state_q;
  assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic [31:0]   load_data = '0;
  logic          load_ready;
  logic          imem_we;
  logic [3:0]    imem_waddr;
  logic [31:0]   imem_wdata;
  logic          hazard_stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic          jump = 1'b0;
  logic          halt_req = 1'b0;
  logic          resume_req = 1'b0;
  logic          reload_req = 1'b0;
  logic          pc_write;
  logic          pc_sel;
  logic          if_flush;
  logic          core_run;
  logic [1:0]    state;
  logic [CW-1:0] fetch_count;

  fetch_sequencer #(
    .DEPTH_WORDS (16),
    .ADDR_W      (4),
    .DRAIN_CYCLES(3),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .hazard_stall(hazard_stall),
    .branch_taken(branch_taken),
    .jump        (jump),
    .halt_req    (halt_req),
    .resume_req  (resume_req),
    .reload_req  (reload_req),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .if_flush    (if_flush),
    .core_run    (core_run),
    .state       (state),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Signal selectors for control checks
  localparam int SIG_STATE = 0, SIG_LRDY = 1, SIG_WE = 2, SIG_PCW = 3,
                 SIG_PCSEL = 4, SIG_FLUSH = 5, SIG_RUN = 6, SIG_FCNT = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  chk_t cq[$];
  wr_t  wq[$];
  chk_t mc;
  wr_t  mw;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      SIG_STATE: return {30'd0, state};
      SIG_LRDY:  return {31'd0, load_ready};
      SIG_WE:    return {31'd0, imem_we};
      SIG_PCW:   return {31'd0, pc_write};
      SIG_PCSEL: return {31'd0, pc_sel};
      SIG_FLUSH: return {31'd0, if_flush};
      SIG_RUN:   return {31'd0, core_run};
      default:   return {{(32-CW){1'b0}}, fetch_count};
    endcase
  endfunction

  // Monitor: memory writes are matched against the expected-write queue;
  // queued control checks are evaluated at the falling edge.
  always @(negedge clk) begin
    if (imem_we) begin
      n_cmp++;
      if (wq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                 imem_waddr, imem_wdata);
      end else begin
        mw = wq.pop_front();
        if (imem_waddr !== mw.addr || imem_wdata !== mw.data) begin
          n_bad++;
          $display("FAIL imem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   imem_waddr, imem_wdata, mw.addr, mw.data);
        end
      end
    end
    while (cq.size() > 0) begin
      mc = cq.pop_front();
      n_cmp++;
      if (obs(mc.sel) !== mc.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h, expected %0h at t=%0t", mc.name, obs(mc.sel), mc.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int sel, input logic [31:0] exp);
    cq.push_back('{name, sel, exp});
  endtask

  task automatic load_words(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i == 3 || i == 7)) begin
        load_valid = 1'b0;
        chk("gap_no_we", SIG_WE, 0);
        step();
      end
      load_valid = 1'b1;
      load_data  = 32'h13 + 32'(i);
      wq.push_back('{4'(i), 32'h13 + 32'(i)});
      if (i == 15) chk("last_word_still_load", SIG_STATE, 0);
      step();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset held, with a stray valid that must not write.
    load_valid = 1'b1;
    #2;
    chk("rst_state", SIG_STATE, 0);
    chk("rst_load_ready", SIG_LRDY, 1);
    chk("rst_imem_we", SIG_WE, 0);
    chk("rst_pc_write", SIG_PCW, 0);
    chk("rst_core_run", SIG_RUN, 0);
    chk("rst_fetch_count", SIG_FCNT, 0);
    #10;
    load_valid = 1'b0;
    reset = 1'b1;
    step();

    // Boot load with gaps on words 3 and 7
    load_words(1'b1);
    chk("boot_state_run", SIG_STATE, 1);
    chk("boot_load_ready", SIG_LRDY, 0);
    chk("boot_core_run", SIG_RUN, 1);
    chk("boot_fcnt0", SIG_FCNT, 0);

    // 10 unstalled cycles
    repeat (10) step();
    chk("fcnt_after_10", SIG_FCNT, 10);

    // Stall alone
    hazard_stall = 1'b1;
    chk("stall_pc_write", SIG_PCW, 0);
    chk("stall_pc_sel", SIG_PCSEL, 0);
    chk("stall_flush", SIG_FLUSH, 0);
    step();
    chk("stall_fcnt_hold", SIG_FCNT, 10);

    // Stall with branch: redirect wins
    branch_taken = 1'b1;
    chk("redir_pc_write", SIG_PCW, 1);
    chk("redir_pc_sel", SIG_PCSEL, 1);
    chk("redir_flush", SIG_FLUSH, 1);
    step();
    hazard_stall = 1'b0;
    branch_taken = 1'b0;
    chk("redir_fcnt", SIG_FCNT, 11);

    // Halt request (this cycle still fetches: count 11 -> 12)
    halt_req = 1'b1;
    chk("halt_cycle_pcw", SIG_PCW, 1);
    step();
    halt_req = 1'b0;
    chk("drain1_state", SIG_STATE, 2);
    chk("drain1_pcw", SIG_PCW, 0);
    chk("drain1_run", SIG_RUN, 1);
    step();
    jump = 1'b1;
    chk("drain2_state", SIG_STATE, 2);
    chk("drain2_pcw", SIG_PCW, 1);
    chk("drain2_pcsel", SIG_PCSEL, 1);
    chk("drain2_flush", SIG_FLUSH, 1);
    step();
    jump = 1'b0;
    chk("drain3_state", SIG_STATE, 2);
    chk("drain3_pcw", SIG_PCW, 0);
    chk("drain3_flush", SIG_FLUSH, 0);
    step();

    // HALT: branch ignored
    branch_taken = 1'b1;
    chk("halt_state", SIG_STATE, 3);
    chk("halt_pcw", SIG_PCW, 0);
    chk("halt_pcsel", SIG_PCSEL, 0);
    chk("halt_run", SIG_RUN, 0);
    chk("halt_fcnt", SIG_FCNT, 13);
    step();
    branch_taken = 1'b0;

    // Resume alone
    resume_req = 1'b1;
    step();
    resume_req = 1'b0;
    chk("resume_state", SIG_STATE, 1);
    chk("resume_fcnt", SIG_FCNT, 13);

    // Halt again; requests inside DRAIN are ignored
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    resume_req = 1'b1;
    reload_req = 1'b1;
    step();
    resume_req = 1'b0;
    reload_req = 1'b0;
    chk("drain_ignores_req", SIG_STATE, 2);
    step();
    step();
    chk("halt2_state", SIG_STATE, 3);
    chk("halt2_fcnt", SIG_FCNT, 14);

    // Resume and reload together: reload wins
    resume_req = 1'b1;
    reload_req = 1'b1;
    step();
    resume_req = 1'b0;
    reload_req = 1'b0;
    chk("reload_state", SIG_STATE, 0);
    chk("reload_fcnt", SIG_FCNT, 0);
    chk("reload_load_ready", SIG_LRDY, 1);
    chk("reload_run", SIG_RUN, 0);

    // Second load, then saturation with a 4-bit counter
    load_words(1'b0);
    chk("load2_state", SIG_STATE, 1);
    repeat (20) step();
    chk("fcnt_saturated", SIG_FCNT, 15);

    // Enter DRAIN, then assert reset between edges
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    step();
    chk("pre_reset_drain", SIG_STATE, 2);
    chk("pre_reset_fcnt_sat", SIG_FCNT, 15);
    step();
    #1;
    reset = 1'b0;
    chk("async_rst_state", SIG_STATE, 0);
    chk("async_rst_run", SIG_RUN, 0);
    chk("async_rst_fcnt", SIG_FCNT, 0);
    chk("async_rst_pcw", SIG_PCW, 0);
    chk("async_rst_lrdy", SIG_LRDY, 1);
    step();
    step();
    reset = 1'b1;
    step();

    n_cmp++;
    if (wq.size() != 0) begin
      n_bad++;
      $display("FAIL missing_writes: got %0d writes outstanding, expected 0", wq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
